// File: rtl/skullfet_pkg.sv
// Shared types, sizes and the reference truth table
// for the skullfet inverter/NAND exerciser.
package skullfet_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // Ideal responses for vector {a,b}: {inv_y, nand_y}
    function automatic logic [1:0] expect_y(input logic [1:0] vec);
        logic va;
        logic vb;
        va = vec[1];
        vb = vec[0];
        return {~va, ~(va & vb)};
    endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// Two-flop synchronizer for an asynchronous return
// from the cell under test.
module skullfet_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/skullfet_exerciser.sv
// Sweeps the four {a,b} vectors through a skullfet
// inverter and NAND, counting mismatching samples.
module skullfet_exerciser
    import skullfet_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inv_y,
    input  logic             nand_y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);
    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t           state;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [7:0]       loop_cnt;
    logic [3:0]       settle;
    logic             inv_s;
    logic             nand_s;
    logic [1:0]       exp_y;
    logic             fail;
    logic [ERR_W-1:0] err_nxt;

    skullfet_sync2 u_sync_inv (
        .clk (clk),
        .rst (rst),
        .d   (inv_y),
        .q   (inv_s)
    );

    skullfet_sync2 u_sync_nand (
        .clk (clk),
        .rst (rst),
        .d   (nand_y),
        .q   (nand_s)
    );

    // Compare synchronized returns and form the saturating count
    always_comb begin
        idx_nxt = idx + 2'd1;
        exp_y   = expect_y(idx);
        fail    = (inv_s != exp_y[1]) || (nand_s != exp_y[0]);
        err_nxt = err_count;
        if (fail && (err_count != ERR_MAX)) begin
            err_nxt = err_count + 8'd1;
        end
    end

    // Run sequencer with registered drives and results
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= 2'd0;
            loop_cnt         <= 8'd0;
            settle           <= 4'd0;
            a                <= 1'b0;
            b                <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= 2'd0;
            first_fail_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= SETTLE;
                        idx              <= 2'd0;
                        loop_cnt         <= 8'd0;
                        settle           <= RELOAD;
                        a                <= 1'b0;
                        b                <= 1'b0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle <= settle - 4'd1;
                    end
                end
                SAMPLE: begin
                    err_count <= err_nxt;
                    settle    <= RELOAD;
                    if (fail && !first_fail_valid) begin
                        first_fail_vec   <= idx;
                        first_fail_valid <= 1'b1;
                    end
                    if (idx != LAST_VEC) begin
                        idx   <= idx_nxt;
                        a     <= idx_nxt[1];
                        b     <= idx_nxt[0];
                        state <= SETTLE;
                    end else if (loop_cnt != LAST_LOOP) begin
                        idx      <= 2'd0;
                        a        <= 1'b0;
                        b        <= 1'b0;
                        loop_cnt <= loop_cnt + 8'd1;
                        state    <= SETTLE;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skullfet_exerciser.sv
// Scoreboard bench: runs queue expected results,
// monitors pop and compare on each rising done.
module tb_skullfet_exerciser;
    import skullfet_pkg::*;

    typedef struct {
        int err;
        int ffv;
        bit vld;
        bit pas;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    int         mode;
    logic       inv_y, nand_y, a, b, busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] ffv;
    logic       ffvalid;
    logic       inv_y2, nand_y2, a2, b2, busy2, done2, pass2;
    logic [7:0] err_count2;
    logic [1:0] ffv2;
    logic       ffvalid2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    logic d1_q = 1'b0;
    logic d2_q = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    skullfet_exerciser #(.SETTLE_CYCLES(4), .LOOPS(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .inv_y(inv_y), .nand_y(nand_y),
        .a(a), .b(b), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count),
        .first_fail_vec(ffv),
        .first_fail_valid(ffvalid)
    );

    skullfet_exerciser #(.SETTLE_CYCLES(4), .LOOPS(255)) dut255 (
        .clk(clk), .rst(rst), .start(start2),
        .inv_y(inv_y2), .nand_y(nand_y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err_count2),
        .first_fail_vec(ffv2),
        .first_fail_valid(ffvalid2)
    );

    // Cell models: 0 ideal, 1 nand stuck 1, 2 inv stuck 0, 3 both inverted
    always_comb begin
        inv_y  = ~a;
        nand_y = ~(a & b);
        case (mode)
            1: nand_y = 1'b1;
            2: inv_y = 1'b0;
            3: begin
                inv_y  = a;
                nand_y = a & b;
            end
            default: ;
        endcase
    end

    assign inv_y2  = a2;
    assign nand_y2 = a2 & b2;

    task automatic chk(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== 32'(req)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done && !d1_q) begin
            if (q1.size() == 0) begin
                chk("mon1_unexpected_done", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("err_count", err_count, e1.err);
                chk("first_fail_valid", ffvalid, int'(e1.vld));
                chk("pass", pass, int'(e1.pas));
                chk("busy_in_done", busy, 0);
                if (e1.vld) chk("first_fail_vec", ffv, e1.ffv);
            end
        end
        d1_q = done;
    end

    always @(negedge clk) begin
        if (done2 && !d2_q) begin
            if (q2.size() == 0) begin
                chk("mon2_unexpected_done", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("sat_err_count", err_count2, e2.err);
                chk("sat_first_fail_valid", ffvalid2, int'(e2.vld));
                chk("sat_pass", pass2, int'(e2.pas));
                if (e2.vld) chk("sat_first_fail_vec", ffv2, e2.ffv);
            end
        end
        d2_q = done2;
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_ffv"}, ffv, 0);
        chk({tag, "_ffvalid"}, ffvalid, 0);
        chk({tag, "_state"}, dut.state, int'(IDLE));
    endtask

    task automatic run1(input int m, input int ee, input int ef,
                        input bit ev, input bit ep, input bit poke);
        exp_t e;
        int k;
        e.err = ee;
        e.ffv = ef;
        e.vld = ev;
        e.pas = ep;
        mode = m;
        q1.push_back(e);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 1;
        chk("accept_busy", busy, 1);
        chk("accept_done_clr", done, 0);
        chk("accept_err_clr", err_count, 0);
        chk("accept_vld_clr", ffvalid, 0);
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
            start = poke && (k == 7 || k == 23);
        end
        start = 1'b0;
        chk("done_latency", k, 41);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", done, 1);
        chk("err_hold", err_count, ee);
    endtask

    initial begin
        int k;
        exp_t e;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;

        run1(0, 0, 0, 1'b0, 1'b1, 1'b0);
        run1(0, 0, 0, 1'b0, 1'b1, 1'b0);
        run1(2, 4, 0, 1'b1, 1'b0, 1'b1);
        run1(1, 2, 3, 1'b1, 1'b0, 1'b0);

        mode = 3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("midrun_busy", busy, 1);
        chk("midrun_err_nonzero", err_count != 0, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        reset_checks("midrst");
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_stays_idle", busy, 0);

        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_state", dut.state, int'(IDLE));

        e.err = 255;
        e.ffv = 0;
        e.vld = 1'b1;
        e.pas = 1'b0;
        q2.push_back(e);
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        k = 1;
        while (!done2 && k < 6000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("sat_latency", k, 255 * 20 + 1);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", q1.size() + q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skullfet_exerciser.md
SKULLFET_EXERCISER -- requirements
Module: skullfet_exerciser

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, cycles a vector is held before sampling; legal range 3..15.
REQ-002 Parameter LOOPS, default 16, full four-vector sweeps per run; legal range 1..255.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a run; honoured only in IDLE or DONE.
REQ-006 inv_y  input  1  asynchronous return from the skullfet inverter output.
REQ-007 nand_y  input  1  asynchronous return from the skullfet NAND output.
REQ-008 a  output  1  drive to the inverter input and NAND input A.
REQ-009 b  output  1  drive to NAND input B.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high in DONE state; results are valid while high.
REQ-012 pass  output  1  done and err_count==0.
REQ-013 err_count  output  8  count of failing samples, saturating.
REQ-014 first_fail_vec  output  2  vector index of the first failing sample in the run.
REQ-015 first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-016 Vector index i counts 0..3; a=i[1], b=i[0]; a and b are registered outputs.
REQ-017 Expected values: inv_y = ~a, nand_y = ~(a&b).
REQ-018 inv_y and nand_y pass through a two-flop synchronizer before comparison; the unsynchronized inputs are never used.
REQ-019 States: IDLE, SETTLE, SAMPLE, DONE.
REQ-020 IDLE/DONE + start=1 -> SETTLE; i=0, loop=0, err_count=0, first_fail_valid=0, settle counter=SETTLE_CYCLES-1.
REQ-021 SETTLE: decrement the counter each cycle; when it reaches 0, go to SAMPLE; a/b stay stable.
REQ-022 SAMPLE (1 cycle): compare synchronized returns to the expected values; a mismatch on either or both outputs counts as one failing sample.
REQ-023 A failing sample increments err_count, saturating at 255.
REQ-024 On the first failing sample of a run: first_fail_vec=i, first_fail_valid=1; later failures leave both unchanged.
REQ-025 SAMPLE with i<3: i+=1, reload the settle counter, go to SETTLE.
REQ-026 SAMPLE with i==3 and loop<LOOPS-1: i=0, loop+=1, go to SETTLE.
REQ-027 SAMPLE with i==3 and loop==LOOPS-1: go to DONE.
REQ-028 Run length is LOOPS*4*(SETTLE_CYCLES+1) cycles in SETTLE/SAMPLE.
REQ-029 busy is high exactly in SETTLE and SAMPLE.
REQ-030 done is high exactly in DONE; the results hold in DONE until the next accepted start.
REQ-031 start while busy is ignored; it is not queued.
REQ-032 DONE + start=1 restarts the run and clears the results on the same edge.

Reset
REQ-033 rst=1 at any clock edge, including mid-run, forces: state=IDLE, a=0, b=0, i=0, loop=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, synchronizer flops=0.
REQ-034 rst has priority over start on the same edge.

Structure
REQ-035 A shared package skullfet_pkg holds the state enum, NUM_VECTORS=4, ERR_W=8, and the expected-value function.
REQ-036 One sub-module, skullfet_sync2 (a 2-flop synchronizer with synchronous active-high reset), is instantiated once per return signal.

Verification
REQ-037 Ideal cell models, SETTLE_CYCLES=4, LOOPS=2, start pulsed -> done rises 41 cycles after the start-accepting edge; pass=1, err_count=0, first_fail_valid=0.
REQ-038 nand_y tied to 1, LOOPS=2 -> err_count=2, first_fail_vec=3, pass=0.
REQ-039 inv_y tied to 0, LOOPS=2 -> err_count=4, first_fail_vec=0.
REQ-040 Both returns inverted from ideal, LOOPS=255 -> err_count saturates at 255 and does not wrap.
REQ-041 start pulsed while busy -> run length and results are unchanged; rst asserted mid-run -> next cycle all outputs are at reset values with state IDLE.
REQ-042 start pulsed in DONE -> results clear on the accepting edge, busy=1 the next cycle, and the second run matches the first.
